// File: rtl/biriscv_issue_sched.sv
// biriscv_issue_sched: in-order dual-issue scheduler with divider scoreboard; define BIRISCV_SINGLE_ISSUE_EN to limit issue to one per cycle
module biriscv_issue_sched #(
  parameter int unsigned DIV_LATENCY = 34,
  parameter bit SUPPORT_MULDIV = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       slot0_valid_i,
  input  logic       slot0_lsu_i,
  input  logic       slot0_mul_i,
  input  logic       slot0_div_i,
  input  logic       slot0_csr_i,
  input  logic       slot0_branch_i,
  input  logic       slot0_invalid_i,
  input  logic       slot0_rd_valid_i,
  input  logic [4:0] slot0_rd_i,
  input  logic [4:0] slot0_rs1_i,
  input  logic [4:0] slot0_rs2_i,
  input  logic       slot1_valid_i,
  input  logic       slot1_lsu_i,
  input  logic       slot1_mul_i,
  input  logic       slot1_div_i,
  input  logic       slot1_csr_i,
  input  logic       slot1_branch_i,
  input  logic       slot1_invalid_i,
  input  logic       slot1_rd_valid_i,
  input  logic [4:0] slot1_rd_i,
  input  logic [4:0] slot1_rs1_i,
  input  logic [4:0] slot1_rs2_i,
  input  logic       stall_i,
  input  logic       flush_i,
  output logic       slot0_accept_o,
  output logic       slot1_accept_o,
  output logic       issue0_valid_o,
  output logic       issue1_valid_o,
  output logic       div_busy_o,
  output logic [4:0] div_rd_o
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t     state_q;
  logic [5:0] count_q;
  logic [4:0] div_rd_q, div_rd_d;
  logic       issue0_q, issue1_q;
  logic       busy, stall_div0, stall_div1, md0, md1, raw, pair_bad, can0, can1, div_start;
  logic       unused_branch1;
  // Hazard detection, pairing legality and the combinational pop decision
  always_comb begin
    busy       = state_q == BUSY;
    stall_div0 = busy & (slot0_div_i | (div_rd_q != 5'd0 & (slot0_rs1_i == div_rd_q | slot0_rs2_i == div_rd_q | (slot0_rd_valid_i & slot0_rd_i == div_rd_q))));
    stall_div1 = busy & (slot1_div_i | (div_rd_q != 5'd0 & (slot1_rs1_i == div_rd_q | slot1_rs2_i == div_rd_q | (slot1_rd_valid_i & slot1_rd_i == div_rd_q))));
    md0        = slot0_mul_i | slot0_div_i;
    md1        = slot1_mul_i | slot1_div_i;
    raw        = slot0_rd_valid_i & slot0_rd_i != 5'd0 &
                 (slot0_rd_i == slot1_rs1_i | slot0_rd_i == slot1_rs2_i | (slot1_rd_valid_i & slot0_rd_i == slot1_rd_i));
    pair_bad   = (slot0_lsu_i & slot1_lsu_i) | (md0 & md1) | slot0_csr_i | slot1_csr_i |
                 slot0_invalid_i | slot1_invalid_i | slot0_branch_i | raw | (!SUPPORT_MULDIV & (md0 | md1));
    can0       = slot0_valid_i & !stall_i & !flush_i & !stall_div0;
    can1       = slot1_valid_i & !stall_i & !flush_i & !stall_div1 & (can0 ? !pair_bad : !slot0_valid_i);
`ifdef BIRISCV_SINGLE_ISSUE_EN
    can1       = can1 & !slot0_valid_i;
`endif
    div_start  = SUPPORT_MULDIV & ((can0 & slot0_div_i) | (can1 & slot1_div_i));
    div_rd_d   = (can0 & slot0_div_i) ? (slot0_rd_valid_i ? slot0_rd_i : 5'd0)
                                      : (slot1_rd_valid_i ? slot1_rd_i : 5'd0);
  end
  // Branch class on slot1 never restricts pairing; only slot0 branches end a pair
  assign unused_branch1 = slot1_branch_i;
  // Divider FSM and registered issue strobes
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      count_q  <= '0;
      div_rd_q <= '0;
      issue0_q <= 1'b0;
      issue1_q <= 1'b0;
    end else begin
      issue0_q <= can0;
      issue1_q <= can1;
      if (state_q == IDLE) begin
        if (div_start) begin
          state_q  <= BUSY;
          count_q  <= 6'(DIV_LATENCY - 1);
          div_rd_q <= div_rd_d;
        end
      end else if (count_q == 6'd0) begin
        state_q  <= IDLE;
        div_rd_q <= '0;
      end else begin
        count_q <= count_q - 6'd1;
        if (flush_i) div_rd_q <= '0;
      end
    end
  end
  assign slot0_accept_o = can0;
  assign slot1_accept_o = can1;
  assign issue0_valid_o = issue0_q;
  assign issue1_valid_o = issue1_q;
  assign div_busy_o     = state_q == BUSY;
  assign div_rd_o       = div_rd_q;
endmodule

// File: tb/tb_biriscv_issue_sched.sv
// tb_biriscv_issue_sched: directed scenarios for the dual-issue scheduler with a 4-cycle divider
module tb_biriscv_issue_sched;
  localparam bit SI =
`ifdef BIRISCV_SINGLE_ISSUE_EN
    1'b1;
`else
    1'b0;
`endif
  logic clk_i = 1'b0, rst_i = 1'b1;
  logic slot0_valid_i, slot0_lsu_i, slot0_mul_i, slot0_div_i, slot0_csr_i, slot0_branch_i, slot0_invalid_i, slot0_rd_valid_i;
  logic slot1_valid_i, slot1_lsu_i, slot1_mul_i, slot1_div_i, slot1_csr_i, slot1_branch_i, slot1_invalid_i, slot1_rd_valid_i;
  logic [4:0] slot0_rd_i, slot0_rs1_i, slot0_rs2_i, slot1_rd_i, slot1_rs1_i, slot1_rs2_i;
  logic stall_i, flush_i;
  logic slot0_accept_o, slot1_accept_o, issue0_valid_o, issue1_valid_o, div_busy_o;
  logic [4:0] div_rd_o;
  int vectors = 0, errs = 0;

  always #5 clk_i = ~clk_i;

  biriscv_issue_sched #(.DIV_LATENCY(4), .SUPPORT_MULDIV(1'b1)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .slot0_valid_i(slot0_valid_i), .slot0_lsu_i(slot0_lsu_i), .slot0_mul_i(slot0_mul_i), .slot0_div_i(slot0_div_i),
    .slot0_csr_i(slot0_csr_i), .slot0_branch_i(slot0_branch_i), .slot0_invalid_i(slot0_invalid_i),
    .slot0_rd_valid_i(slot0_rd_valid_i), .slot0_rd_i(slot0_rd_i), .slot0_rs1_i(slot0_rs1_i), .slot0_rs2_i(slot0_rs2_i),
    .slot1_valid_i(slot1_valid_i), .slot1_lsu_i(slot1_lsu_i), .slot1_mul_i(slot1_mul_i), .slot1_div_i(slot1_div_i),
    .slot1_csr_i(slot1_csr_i), .slot1_branch_i(slot1_branch_i), .slot1_invalid_i(slot1_invalid_i),
    .slot1_rd_valid_i(slot1_rd_valid_i), .slot1_rd_i(slot1_rd_i), .slot1_rs1_i(slot1_rs1_i), .slot1_rs2_i(slot1_rs2_i),
    .stall_i(stall_i), .flush_i(flush_i),
    .slot0_accept_o(slot0_accept_o), .slot1_accept_o(slot1_accept_o),
    .issue0_valid_o(issue0_valid_o), .issue1_valid_o(issue1_valid_o),
    .div_busy_o(div_busy_o), .div_rd_o(div_rd_o)
  );

  task clr;
    {slot0_valid_i, slot0_lsu_i, slot0_mul_i, slot0_div_i, slot0_csr_i, slot0_branch_i, slot0_invalid_i, slot0_rd_valid_i} = '0;
    {slot1_valid_i, slot1_lsu_i, slot1_mul_i, slot1_div_i, slot1_csr_i, slot1_branch_i, slot1_invalid_i, slot1_rd_valid_i} = '0;
    {slot0_rd_i, slot0_rs1_i, slot0_rs2_i, slot1_rd_i, slot1_rs1_i, slot1_rs2_i} = '0;
    stall_i = 1'b0;
    flush_i = 1'b0;
  endtask

  task set0(input logic lsu, mul, dv, csr, br, inv, rdv, input logic [4:0] rd, rs1, rs2);
    {slot0_valid_i, slot0_lsu_i, slot0_mul_i, slot0_div_i, slot0_csr_i, slot0_branch_i, slot0_invalid_i, slot0_rd_valid_i} = {1'b1, lsu, mul, dv, csr, br, inv, rdv};
    {slot0_rd_i, slot0_rs1_i, slot0_rs2_i} = {rd, rs1, rs2};
  endtask

  task set1(input logic lsu, mul, dv, csr, br, inv, rdv, input logic [4:0] rd, rs1, rs2);
    {slot1_valid_i, slot1_lsu_i, slot1_mul_i, slot1_div_i, slot1_csr_i, slot1_branch_i, slot1_invalid_i, slot1_rd_valid_i} = {1'b1, lsu, mul, dv, csr, br, inv, rdv};
    {slot1_rd_i, slot1_rs1_i, slot1_rs2_i} = {rd, rs1, rs2};
  endtask

  task test_reset;
    clr();
    #2;
    vectors++; if (issue0_valid_o !== 1'b0) begin errs++; $display("FAIL reset_issue0 got %b want 0", issue0_valid_o); end
    vectors++; if (issue1_valid_o !== 1'b0) begin errs++; $display("FAIL reset_issue1 got %b want 0", issue1_valid_o); end
    vectors++; if (div_busy_o !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", div_busy_o); end
    vectors++; if (div_rd_o !== 5'd0) begin errs++; $display("FAIL reset_div_rd got %0d want 0", div_rd_o); end
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  // Slots are already driven; ok says whether the two may issue together under dual issue
  task run_pair(input string nm, input logic ok);
    logic first;
    first = ok & !SI;
    #1;
    vectors++; if (slot0_accept_o !== 1'b1) begin errs++; $display("FAIL %s_a0 got %b want 1", nm, slot0_accept_o); end
    vectors++; if (slot1_accept_o !== first) begin errs++; $display("FAIL %s_a1 got %b want %b", nm, slot1_accept_o, first); end
    @(negedge clk_i);
    vectors++; if (issue0_valid_o !== 1'b1) begin errs++; $display("FAIL %s_i0 got %b want 1", nm, issue0_valid_o); end
    vectors++; if (issue1_valid_o !== first) begin errs++; $display("FAIL %s_i1 got %b want %b", nm, issue1_valid_o, first); end
    slot0_valid_i = 1'b0;
    slot1_valid_i = !first;
    #1;
    vectors++; if (slot0_accept_o !== 1'b0) begin errs++; $display("FAIL %s_b0 got %b want 0", nm, slot0_accept_o); end
    vectors++; if (slot1_accept_o !== !first) begin errs++; $display("FAIL %s_b1 got %b want %b", nm, slot1_accept_o, !first); end
    @(negedge clk_i);
    vectors++; if (issue0_valid_o !== 1'b0) begin errs++; $display("FAIL %s_j0 got %b want 0", nm, issue0_valid_o); end
    vectors++; if (issue1_valid_o !== !first) begin errs++; $display("FAIL %s_j1 got %b want %b", nm, issue1_valid_o, !first); end
    clr();
  endtask

  task test_pair;
    @(negedge clk_i); clr();
    set0(0, 0, 0, 0, 0, 0, 1, 5, 1, 2);
    set1(1, 0, 0, 0, 0, 0, 1, 6, 2, 0);
    run_pair("pair", 1'b1);
  endtask

  task test_raw;
    @(negedge clk_i); clr();
    set0(0, 0, 0, 0, 0, 0, 1, 5, 1, 2);
    set1(0, 0, 0, 0, 0, 0, 1, 6, 3, 5);
    run_pair("raw", 1'b0);
    @(negedge clk_i); clr();
    set0(0, 0, 0, 0, 0, 0, 1, 0, 1, 2);
    set1(0, 0, 0, 0, 0, 0, 1, 6, 3, 0);
    run_pair("raw_x0", 1'b1);
  endtask

  task test_struct;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk_i); clr();
      case (i)
        0: begin set0(1, 0, 0, 0, 0, 0, 1, 5, 1, 2); set1(1, 0, 0, 0, 0, 0, 1, 6, 3, 4); end
        1: begin set0(0, 1, 0, 0, 0, 0, 1, 5, 1, 2); set1(0, 1, 0, 0, 0, 0, 1, 6, 3, 4); end
        2: begin set0(0, 0, 0, 0, 1, 0, 0, 0, 1, 2); set1(0, 0, 0, 0, 0, 0, 1, 6, 3, 4); end
        3: begin set0(0, 0, 0, 0, 0, 0, 1, 5, 1, 2); set1(0, 0, 0, 1, 0, 0, 1, 6, 3, 4); end
        4: begin set0(0, 0, 0, 0, 0, 1, 0, 0, 0, 0); set1(0, 0, 0, 0, 0, 0, 1, 6, 3, 4); end
        5: begin set0(0, 0, 0, 0, 0, 0, 1, 9, 1, 2); set1(0, 0, 0, 0, 0, 0, 1, 9, 3, 4); end
        default: begin set0(0, 0, 0, 0, 0, 0, 1, 5, 1, 2); set1(0, 0, 0, 0, 1, 0, 0, 0, 3, 4); end
      endcase
      run_pair($sformatf("struct%0d", i), i == 6);
    end
  endtask

  task test_div;
    @(negedge clk_i); clr();
    set0(0, 0, 1, 0, 0, 0, 1, 7, 1, 2);
    #1;
    vectors++; if (slot0_accept_o !== 1'b1) begin errs++; $display("FAIL div_accept got %b want 1", slot0_accept_o); end
    @(negedge clk_i); clr();
    set0(0, 0, 0, 0, 0, 0, 1, 8, 7, 0);
    for (int k = 1; k <= 4; k++) begin
      #1;
      vectors++; if (div_busy_o !== 1'b1) begin errs++; $display("FAIL div_busy%0d got %b want 1", k, div_busy_o); end
      vectors++; if (div_rd_o !== 5'd7) begin errs++; $display("FAIL div_rd%0d got %0d want 7", k, div_rd_o); end
      vectors++; if (slot0_accept_o !== 1'b0) begin errs++; $display("FAIL div_hold%0d got %b want 0", k, slot0_accept_o); end
      if (k == 1) begin
        set0(0, 0, 0, 0, 0, 0, 1, 8, 3, 0);
        #1;
        vectors++; if (slot0_accept_o !== 1'b1) begin errs++; $display("FAIL div_indep got %b want 1", slot0_accept_o); end
        set0(0, 0, 1, 0, 0, 0, 1, 9, 3, 0);
        #1;
        vectors++; if (slot0_accept_o !== 1'b0) begin errs++; $display("FAIL div_second got %b want 0", slot0_accept_o); end
        set0(0, 0, 0, 0, 0, 0, 1, 8, 7, 0);
      end
      if (k == 2) begin
        clr();
        set1(0, 0, 0, 0, 0, 0, 1, 10, 3, 7);
        #1;
        vectors++; if (slot1_accept_o !== 1'b0) begin errs++; $display("FAIL div_slot1 got %b want 0", slot1_accept_o); end
        clr();
        set0(0, 0, 0, 0, 0, 0, 1, 8, 7, 0);
      end
      @(negedge clk_i);
    end
    #1;
    vectors++; if (div_busy_o !== 1'b0) begin errs++; $display("FAIL div_done got %b want 0", div_busy_o); end
    vectors++; if (div_rd_o !== 5'd0) begin errs++; $display("FAIL div_rd_done got %0d want 0", div_rd_o); end
    vectors++; if (slot0_accept_o !== 1'b1) begin errs++; $display("FAIL div_release got %b want 1", slot0_accept_o); end
    @(negedge clk_i);
    vectors++; if (issue0_valid_o !== 1'b1) begin errs++; $display("FAIL div_release_i0 got %b want 1", issue0_valid_o); end
    clr();
  endtask

  task test_flush;
    @(negedge clk_i); clr();
    set0(0, 0, 1, 0, 0, 0, 1, 7, 1, 2);
    #1;
    vectors++; if (slot0_accept_o !== 1'b1) begin errs++; $display("FAIL fl_div got %b want 1", slot0_accept_o); end
    @(negedge clk_i); clr();
    @(negedge clk_i);
    flush_i = 1'b1;
    set0(0, 0, 0, 0, 0, 0, 1, 8, 9, 0);
    set1(0, 0, 0, 0, 0, 0, 1, 11, 3, 4);
    #1;
    vectors++; if (slot0_accept_o !== 1'b0) begin errs++; $display("FAIL fl_a0 got %b want 0", slot0_accept_o); end
    vectors++; if (slot1_accept_o !== 1'b0) begin errs++; $display("FAIL fl_a1 got %b want 0", slot1_accept_o); end
    @(negedge clk_i);
    vectors++; if (div_rd_o !== 5'd0) begin errs++; $display("FAIL fl_div_rd got %0d want 0", div_rd_o); end
    vectors++; if (div_busy_o !== 1'b1) begin errs++; $display("FAIL fl_busy got %b want 1", div_busy_o); end
    vectors++; if (issue0_valid_o !== 1'b0) begin errs++; $display("FAIL fl_i0 got %b want 0", issue0_valid_o); end
    clr();
    set0(0, 0, 0, 0, 0, 0, 1, 8, 7, 0);
    #1;
    vectors++; if (slot0_accept_o !== 1'b1) begin errs++; $display("FAIL fl_old_rd got %b want 1", slot0_accept_o); end
    @(negedge clk_i);
    vectors++; if (issue0_valid_o !== 1'b1) begin errs++; $display("FAIL fl_old_rd_i0 got %b want 1", issue0_valid_o); end
    vectors++; if (div_busy_o !== 1'b1) begin errs++; $display("FAIL fl_busy_last got %b want 1", div_busy_o); end
    clr();
    @(negedge clk_i);
    vectors++; if (div_busy_o !== 1'b0) begin errs++; $display("FAIL fl_busy_end got %b want 0", div_busy_o); end
  endtask

  task test_stall;
    @(negedge clk_i); clr();
    set0(0, 0, 0, 0, 0, 0, 1, 5, 1, 2);
    @(negedge clk_i);
    stall_i = 1'b1;
    set1(0, 0, 0, 0, 0, 0, 1, 6, 3, 4);
    #1;
    vectors++; if (slot0_accept_o !== 1'b0) begin errs++; $display("FAIL st_a0 got %b want 0", slot0_accept_o); end
    vectors++; if (slot1_accept_o !== 1'b0) begin errs++; $display("FAIL st_a1 got %b want 0", slot1_accept_o); end
    @(negedge clk_i);
    vectors++; if (issue0_valid_o !== 1'b0) begin errs++; $display("FAIL st_i0 got %b want 0", issue0_valid_o); end
    vectors++; if (issue1_valid_o !== 1'b0) begin errs++; $display("FAIL st_i1 got %b want 0", issue1_valid_o); end
    clr();
  endtask

  task test_async_reset;
    @(negedge clk_i); clr();
    set0(0, 0, 1, 0, 0, 0, 1, 7, 1, 2);
    @(negedge clk_i); clr();
    stall_i = 1'b1;
    set0(0, 0, 0, 0, 0, 0, 1, 5, 1, 2);
    set1(1, 0, 0, 0, 0, 0, 1, 6, 2, 0);
    #1;
    vectors++; if (div_busy_o !== 1'b1) begin errs++; $display("FAIL ar_busy_pre got %b want 1", div_busy_o); end
    vectors++; if (issue0_valid_o !== 1'b1) begin errs++; $display("FAIL ar_i0_pre got %b want 1", issue0_valid_o); end
    #1 rst_i = 1'b1;
    #1;
    vectors++; if (div_busy_o !== 1'b0) begin errs++; $display("FAIL ar_busy got %b want 0", div_busy_o); end
    vectors++; if (div_rd_o !== 5'd0) begin errs++; $display("FAIL ar_div_rd got %0d want 0", div_rd_o); end
    vectors++; if (issue0_valid_o !== 1'b0) begin errs++; $display("FAIL ar_i0 got %b want 0", issue0_valid_o); end
    vectors++; if (issue1_valid_o !== 1'b0) begin errs++; $display("FAIL ar_i1 got %b want 0", issue1_valid_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
    clr();
    @(negedge clk_i);
    vectors++; if (div_busy_o !== 1'b0) begin errs++; $display("FAIL ar_busy_after got %b want 0", div_busy_o); end
  endtask

  initial begin
    test_reset();
    test_pair();
    test_raw();
    test_struct();
    test_div();
    test_flush();
    test_stall();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
